// File: rtl/mmu_pkg.sv
// Shared MMU types: page size, PTE bit positions and the TLB entry record.
// The asid field of tlb_entry_t exists only when TLB_ASID_EN is defined.
package mmu;

    typedef enum logic [1:0] {
        PSIZE_4K = 2'd0,
        PSIZE_2M = 2'd1,
        PSIZE_1G = 2'd2
    } psize_t;

    localparam int ASID_W    = 16;
    localparam int VLEN_DEF  = 39;
    localparam int VPN_W_DEF = VLEN_DEF - 12;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_D = 7;

    typedef struct packed {
        logic                 valid;
        logic [VPN_W_DEF-1:0] vpn;
        psize_t               psize;
        logic [31:0]          pte;
`ifdef TLB_ASID_EN
        logic [ASID_W-1:0]    asid;
`endif
    } tlb_entry_t;

    // Number of low VPN bits that a page of this size does not translate.
    function automatic int unsigned gran_bits(input psize_t ps);
        case (ps)
            PSIZE_2M: return 9;
            PSIZE_1G: return 18;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/tlb_entry_cmp.sv
// Combinational single-entry matcher: hit, permission fault, D-bit fault and paddr.
// With TLB_ASID_EN defined, a hit also needs equal ASIDs or a global PTE.
module tlb_entry_cmp
    import mmu::*;
#(
    parameter int VLEN = 39,
    parameter int PLEN = 33
) (
    input  logic              valid_i,
    input  logic [VLEN-13:0]  vpn_i,
    input  psize_t            psize_i,
    input  logic [31:0]       pte_i,
`ifdef TLB_ASID_EN
    input  logic [ASID_W-1:0] entry_asid_i,
    input  logic [ASID_W-1:0] req_asid_i,
`endif
    input  logic [VLEN-1:0]   vaddr_i,
    input  logic              access_r_i,
    input  logic              access_w_i,
    input  logic              access_x_i,
    input  logic              u_mode_i,
    input  logic              sum_i,
    output logic              match_o,
    output logic              fault_o,
    output logic              fault_dns_o,
    output logic [PLEN-1:0]   paddr_o
);

    localparam int VPN_W = VLEN - 12;

    logic [VPN_W-1:0] gran_mask;
    logic             vpn_hit;
    logic             asid_ok;
    logic             xwr_rsvd;
    logic             grant_r, grant_w, grant_x;
    logic             ctx_ok;
    logic             perm_ok;
    logic [32:0]      paddr_full;
    logic             unused_pte_bits;

    assign gran_mask = {VPN_W{1'b1}} << gran_bits(psize_i);
    assign vpn_hit   = ((vpn_i ^ vaddr_i[VLEN-1:12]) & gran_mask) == '0;

`ifdef TLB_ASID_EN
    assign asid_ok = (entry_asid_i == req_asid_i) || pte_i[PTE_G];
`else
    assign asid_ok = 1'b1;
`endif

    assign match_o = valid_i & pte_i[PTE_V] & vpn_hit & asid_ok;

    // XWR = 010 and 110 are reserved and grant nothing at all.
    assign xwr_rsvd = pte_i[PTE_W] & ~pte_i[PTE_R];
    assign grant_r  = pte_i[PTE_R] & ~xwr_rsvd;
    assign grant_w  = pte_i[PTE_W] & ~xwr_rsvd;
    assign grant_x  = pte_i[PTE_X] & ~xwr_rsvd;

    assign ctx_ok  = (u_mode_i == pte_i[PTE_U]) || (!u_mode_i && sum_i);
    assign perm_ok = (access_r_i & grant_r)
                   | (access_w_i & grant_w & pte_i[PTE_D])
                   | (access_x_i & grant_x);

    assign fault_o     = match_o & ~(perm_ok & ctx_ok);
    assign fault_dns_o = match_o & access_w_i & grant_w & ~pte_i[PTE_D] & ctx_ok;

    always_comb begin
        paddr_full = {pte_i[30:10], vaddr_i[11:0]};
        case (psize_i)
            PSIZE_2M: paddr_full = {pte_i[30:19], vaddr_i[20:0]};
            PSIZE_1G: paddr_full = {pte_i[30:28], vaddr_i[29:0]};
            default:  paddr_full = {pte_i[30:10], vaddr_i[11:0]};
        endcase
    end

    assign paddr_o = PLEN'(paddr_full);

    assign unused_pte_bits = ^{pte_i[31], pte_i[9:8], pte_i[6], pte_i[5]};

endmodule

// File: rtl/tlb_array.sv
// Fully associative TLB: registered lookup, walker refill with de-dup/round-robin
// replacement, and flush-all / flush-by-address. TLB_ASID_EN adds ASID tagging.
module tlb_array
    import mmu::*;
#(
    parameter int ENTRIES = 8,
    parameter int VLEN    = 39,
    parameter int PLEN    = 33
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [VLEN-1:0]   lookup_vaddr,
    input  logic              access_r,
    input  logic              access_w,
    input  logic              access_x,
    input  logic              u_mode,
    input  logic              sum,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              resp_fault,
    output logic              resp_fault_dns,
    output logic [PLEN-1:0]   resp_paddr,
    input  logic              fill_valid,
    input  logic [VLEN-13:0]  fill_vpn,
    input  psize_t            fill_psize,
    input  logic [31:0]       fill_pte,
`ifdef TLB_ASID_EN
    input  logic [ASID_W-1:0] lookup_asid,
    input  logic [ASID_W-1:0] fill_asid,
    input  logic [ASID_W-1:0] flush_asid,
    input  logic              flush_by_asid,
`endif
    input  logic              flush_valid,
    input  logic              flush_by_addr,
    input  logic [VLEN-1:0]   flush_vaddr
);

    localparam int VPN_W = VLEN - 12;
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [VPN_W-1:0]   vpn_q   [ENTRIES];
    psize_t             psize_q [ENTRIES];
    logic [31:0]        pte_q   [ENTRIES];
`ifdef TLB_ASID_EN
    logic [ASID_W-1:0]  asid_q  [ENTRIES];
`endif
    logic [IDX_W-1:0]   victim_q, victim_d;

    logic               resp_valid_q, resp_hit_q, resp_fault_q, resp_dns_q;
    logic [PLEN-1:0]    resp_paddr_q;

    logic [ENTRIES-1:0] lk_match, lk_fault, lk_dns, fl_match;
    logic [PLEN-1:0]    lk_paddr [ENTRIES];
    logic [ENTRIES-1:0] unused_fl_fault, unused_fl_dns;
    logic [PLEN-1:0]    unused_fl_paddr [ENTRIES];

    logic               hit_any, sel_fault, sel_dns;
    logic [PLEN-1:0]    sel_paddr;

    logic [VPN_W-1:0]   fill_mask;
    logic               dup_hit, inv_hit, fill_we;
    logic [IDX_W-1:0]   dup_idx, inv_idx, fill_idx;
    logic [ENTRIES-1:0] flush_clr;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        tlb_entry_cmp #(.VLEN(VLEN), .PLEN(PLEN)) u_lookup_cmp (
            .valid_i      (valid_q[i]),
            .vpn_i        (vpn_q[i]),
            .psize_i      (psize_q[i]),
            .pte_i        (pte_q[i]),
`ifdef TLB_ASID_EN
            .entry_asid_i (asid_q[i]),
            .req_asid_i   (lookup_asid),
`endif
            .vaddr_i      (lookup_vaddr),
            .access_r_i   (access_r),
            .access_w_i   (access_w),
            .access_x_i   (access_x),
            .u_mode_i     (u_mode),
            .sum_i        (sum),
            .match_o      (lk_match[i]),
            .fault_o      (lk_fault[i]),
            .fault_dns_o  (lk_dns[i]),
            .paddr_o      (lk_paddr[i])
        );

        // Address flush ignores ASID here; the ASID filter is applied separately.
        tlb_entry_cmp #(.VLEN(VLEN), .PLEN(PLEN)) u_flush_cmp (
            .valid_i      (valid_q[i]),
            .vpn_i        (vpn_q[i]),
            .psize_i      (psize_q[i]),
            .pte_i        (pte_q[i]),
`ifdef TLB_ASID_EN
            .entry_asid_i (asid_q[i]),
            .req_asid_i   (asid_q[i]),
`endif
            .vaddr_i      (flush_vaddr),
            .access_r_i   (1'b0),
            .access_w_i   (1'b0),
            .access_x_i   (1'b0),
            .u_mode_i     (1'b0),
            .sum_i        (1'b0),
            .match_o      (fl_match[i]),
            .fault_o      (unused_fl_fault[i]),
            .fault_dns_o  (unused_fl_dns[i]),
            .paddr_o      (unused_fl_paddr[i])
        );
    end

    always_comb begin
        hit_any   = 1'b0;
        sel_fault = 1'b0;
        sel_dns   = 1'b0;
        sel_paddr = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (lk_match[i]) begin
                hit_any   = 1'b1;
                sel_fault = lk_fault[i];
                sel_dns   = lk_dns[i];
                sel_paddr = lk_paddr[i];
            end
        end
    end

    assign fill_mask = {VPN_W{1'b1}} << gran_bits(fill_psize);

    always_comb begin
        dup_hit = 1'b0;
        dup_idx = '0;
        inv_hit = 1'b0;
        inv_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (((vpn_q[i] ^ fill_vpn) & fill_mask) == '0)
`ifdef TLB_ASID_EN
                && (asid_q[i] == fill_asid)
`endif
               ) begin
                dup_hit = 1'b1;
                dup_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                inv_hit = 1'b1;
                inv_idx = IDX_W'(i);
            end
        end
    end

    assign fill_we  = fill_valid & ~flush_valid;
    assign fill_idx = dup_hit ? dup_idx : (inv_hit ? inv_idx : victim_q);

    always_comb begin
        flush_clr = '0;
        for (int i = 0; i < ENTRIES; i++) begin
`ifdef TLB_ASID_EN
            flush_clr[i] = (!flush_by_addr || fl_match[i]) &&
                           (!flush_by_asid || (!pte_q[i][PTE_G] && asid_q[i] == flush_asid));
`else
            flush_clr[i] = !flush_by_addr || fl_match[i];
`endif
        end
    end

    always_comb begin
        valid_d  = valid_q;
        victim_d = victim_q;
        if (flush_valid) begin
            valid_d = valid_q & ~flush_clr;
        end else if (fill_valid) begin
            valid_d[fill_idx] = 1'b1;
            if (!dup_hit && !inv_hit) begin
                victim_d = victim_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            victim_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_dns_q   <= 1'b0;
            resp_paddr_q <= '0;
        end else begin
            valid_q      <= valid_d;
            victim_q     <= victim_d;
            resp_valid_q <= lookup_valid;
            resp_hit_q   <= lookup_valid & hit_any;
            resp_fault_q <= lookup_valid & sel_fault;
            resp_dns_q   <= lookup_valid & sel_dns;
            resp_paddr_q <= (lookup_valid && hit_any) ? sel_paddr : '0;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            vpn_q[fill_idx]   <= fill_vpn;
            psize_q[fill_idx] <= fill_psize;
            pte_q[fill_idx]   <= fill_pte;
`ifdef TLB_ASID_EN
            asid_q[fill_idx]  <= fill_asid;
`endif
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_hit       = resp_hit_q;
    assign resp_fault     = resp_fault_q;
    assign resp_fault_dns = resp_dns_q;
    assign resp_paddr     = resp_paddr_q;

endmodule

// File: tb/tb_tlb_array.sv
// Self-checking bench for tlb_array: directed scenarios plus random traffic
// against a behavioural TLB model.
module tb_tlb_array;
    import mmu::*;

    localparam int ENTRIES = 8;
    localparam int VLEN    = 39;
    localparam int PLEN    = 33;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            lookup_valid = 1'b0;
    logic [VLEN-1:0] lookup_vaddr = '0;
    logic            access_r = 1'b0, access_w = 1'b0, access_x = 1'b0;
    logic            u_mode = 1'b0, sum = 1'b0;
    logic            resp_valid, resp_hit, resp_fault, resp_fault_dns;
    logic [PLEN-1:0] resp_paddr;
    logic            fill_valid = 1'b0;
    logic [VLEN-13:0] fill_vpn = '0;
    psize_t          fill_psize = PSIZE_4K;
    logic [31:0]     fill_pte = '0;
    logic            flush_valid = 1'b0, flush_by_addr = 1'b0;
    logic [VLEN-1:0] flush_vaddr = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model
    bit          m_valid [ENTRIES];
    logic [26:0] m_vpn   [ENTRIES];
    int          m_ps    [ENTRIES];
    logic [31:0] m_pte   [ENTRIES];
    int          m_victim;

    bit          cur_v = 0, cur_h = 0, cur_f = 0, cur_d = 0;
    logic [32:0] cur_p = '0;

    tlb_array #(.ENTRIES(ENTRIES), .VLEN(VLEN), .PLEN(PLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_valid   (lookup_valid),
        .lookup_vaddr   (lookup_vaddr),
        .access_r       (access_r),
        .access_w       (access_w),
        .access_x       (access_x),
        .u_mode         (u_mode),
        .sum            (sum),
        .resp_valid     (resp_valid),
        .resp_hit       (resp_hit),
        .resp_fault     (resp_fault),
        .resp_fault_dns (resp_fault_dns),
        .resp_paddr     (resp_paddr),
        .fill_valid     (fill_valid),
        .fill_vpn       (fill_vpn),
        .fill_psize     (fill_psize),
        .fill_pte       (fill_pte),
`ifdef TLB_ASID_EN
        .lookup_asid    (16'd0),
        .fill_asid      (16'd0),
        .flush_asid     (16'd0),
        .flush_by_asid  (1'b0),
`endif
        .flush_valid    (flush_valid),
        .flush_by_addr  (flush_by_addr),
        .flush_vaddr    (flush_vaddr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("resp_valid", 64'(resp_valid), 64'(cur_v));
        chk("resp_hit", 64'(resp_hit), 64'(cur_h));
        chk("resp_fault", 64'(resp_fault), 64'(cur_f));
        chk("resp_fault_dns", 64'(resp_fault_dns), 64'(cur_d));
        if (cur_v && cur_h && !cur_f)
            chk("resp_paddr", 64'(resp_paddr), 64'(cur_p));
    end

    function automatic int shift_of(input int ps);
        return (ps == 1) ? 9 : (ps == 2) ? 18 : 0;
    endfunction

    function automatic bit covers(input int e, input logic [VLEN-1:0] va);
        int sh = shift_of(m_ps[e]);
        logic [26:0] pg = va[38:12];
        return m_valid[e] && m_pte[e][0] && ((m_vpn[e] >> sh) == (pg >> sh));
    endfunction

    function automatic void model_lookup(output bit h, output bit f, output bit d,
                                         output logic [32:0] p);
        bit found = 0;
        h = 0; f = 0; d = 0; p = '0;
        if (!lookup_valid) return;
        for (int e = 0; e < ENTRIES; e++) begin
            if (!found && covers(e, lookup_vaddr)) begin
                logic [31:0] pte = m_pte[e];
                int sh = shift_of(m_ps[e]);
                int off = 12 + sh;
                bit gr = 0, gw = 0, gx = 0, ctx, ok;
                case (pte[3:1])
                    3'b001: gr = 1;
                    3'b011: begin gr = 1; gw = 1; end
                    3'b100: gx = 1;
                    3'b101: begin gr = 1; gx = 1; end
                    3'b111: begin gr = 1; gw = 1; gx = 1; end
                    default: ;
                endcase
                ctx = u_mode ? pte[4] : (!pte[4] || sum);
                ok  = access_r ? gr : access_w ? (gw && pte[7]) : gx;
                found = 1;
                h = 1;
                f = !(ok && ctx);
                d = access_w && gw && !pte[7] && ctx;
                p = 33'(((64'(pte[30:10]) >> sh) << off) |
                        (64'(lookup_vaddr) & ((64'd1 << off) - 64'd1)));
            end
        end
    endfunction

    function automatic void model_update();
        if (flush_valid) begin
            for (int e = 0; e < ENTRIES; e++)
                if (!flush_by_addr || covers(e, flush_vaddr)) m_valid[e] = 0;
        end else if (fill_valid) begin
            int sh = shift_of(int'(fill_psize));
            int tgt = -1;
            for (int e = 0; e < ENTRIES; e++)
                if (tgt < 0 && m_valid[e] && ((m_vpn[e] >> sh) == (fill_vpn >> sh))) tgt = e;
            for (int e = 0; e < ENTRIES; e++)
                if (tgt < 0 && !m_valid[e]) tgt = e;
            if (tgt < 0) begin
                tgt = m_victim;
                m_victim = (m_victim + 1) % ENTRIES;
            end
            m_valid[tgt] = 1;
            m_vpn[tgt]   = fill_vpn;
            m_ps[tgt]    = int'(fill_psize);
            m_pte[tgt]   = fill_pte;
        end
    endfunction

    task automatic tick();
        bit h, f, d;
        logic [32:0] p;
        bit v = lookup_valid;
        model_lookup(h, f, d, p);
        model_update();
        @(posedge clk);
        #1;
        cur_v = v; cur_h = h; cur_f = f; cur_d = d; cur_p = p;
    endtask

    task automatic clear_inputs();
        lookup_valid = 0; fill_valid = 0; flush_valid = 0;
        access_r = 0; access_w = 0; access_x = 0;
    endtask

    task automatic set_acc(input int a);
        access_r = (a == 0); access_w = (a == 1); access_x = (a == 2);
    endtask

    task automatic model_reset();
        for (int e = 0; e < ENTRIES; e++) m_valid[e] = 0;
        m_victim = 0;
        cur_v = 0; cur_h = 0; cur_f = 0; cur_d = 0; cur_p = '0;
    endtask

    // Reset asserted with a lookup pending in the same cycle.
    task automatic do_reset();
        reset = 1;
        lookup_valid = 1;
        lookup_vaddr = {$urandom(), $urandom()};
        set_acc(0);
        model_reset();
        #1;
        chk("reset resp_valid", 64'(resp_valid), 64'd0);
        chk("reset resp_hit", 64'(resp_hit), 64'd0);
        @(posedge clk);
        #1;
        reset = 0;
        clear_inputs();
        cur_v = 0; cur_h = 0; cur_f = 0; cur_d = 0;
    endtask

    task automatic do_fill(input logic [26:0] vpn, input psize_t ps, input logic [31:0] pte);
        clear_inputs();
        fill_valid = 1; fill_vpn = vpn; fill_psize = ps; fill_pte = pte;
        tick();
        clear_inputs();
    endtask

    task automatic do_flush(input bit by_addr, input logic [38:0] va);
        clear_inputs();
        flush_valid = 1; flush_by_addr = by_addr; flush_vaddr = va;
        tick();
        clear_inputs();
    endtask

    task automatic do_lookup(input logic [38:0] va, input int a);
        clear_inputs();
        lookup_valid = 1; lookup_vaddr = va; set_acc(a);
        u_mode = 0; sum = 0;
        tick();
        clear_inputs();
    endtask

    logic [26:0] pool [8];

    function automatic logic [26:0] rand_vpn();
        logic [26:0] v = pool[$urandom_range(0, 7)];
        if ($urandom_range(0, 3) == 0) v[8:0] = 9'($urandom());
        if ($urandom_range(0, 7) == 0) v[17:9] = 9'($urandom());
        return v;
    endfunction

    initial begin
        pool[0] = 27'h0000100; pool[1] = 27'h0000101; pool[2] = 27'h0000300;
        pool[3] = 27'h0040000; pool[4] = 27'h0040123; pool[5] = 27'h1234567;
        pool[6] = 27'h7FFFFFF; pool[7] = 27'h0000000;
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
        chk("por resp_valid", 64'(resp_valid), 64'd0);
        chk("por resp_hit", 64'(resp_hit), 64'd0);
        chk("por resp_paddr", 64'(resp_paddr), 64'd0);

        // Basic 4KB translation.
        do_fill(27'h12345, PSIZE_4K, 32'h002AF087);
        do_lookup(39'h12345678, 0);
        chk("4k hit", 64'(resp_hit), 64'd1);
        chk("4k fault", 64'(resp_fault), 64'd0);
        chk("4k paddr", 64'(resp_paddr), 64'h00ABC678);

        // 2MB RX entry written to; then RW entry with D clear.
        do_fill(27'h400, PSIZE_2M, 32'h0010004B);
        do_lookup(39'h412345, 1);
        chk("rx write hit", 64'(resp_hit), 64'd1);
        chk("rx write fault", 64'(resp_fault), 64'd1);
        chk("rx write dns", 64'(resp_fault_dns), 64'd0);
        do_fill(27'h800, PSIZE_2M, 32'h00200047);
        do_lookup(39'h800010, 1);
        chk("rw nod fault", 64'(resp_fault), 64'd1);
        chk("rw nod dns", 64'(resp_fault_dns), 64'd1);
        do_lookup(39'h412345, 2);
        chk("rx exec fault", 64'(resp_fault), 64'd0);
        chk("rx exec paddr", 64'(resp_paddr), 64'h00412345);

        // Round-robin replacement once all entries are valid.
        do_flush(0, '0);
        for (int k = 0; k < 8; k++)
            do_fill(27'(27'h100 + k), PSIZE_4K, ((32'h200 + 32'(k)) << 10) | 32'h47);
        do_fill(27'h108, PSIZE_4K, (32'h208 << 10) | 32'h47);
        do_lookup(39'h100000, 0);
        chk("repl0 evicted", 64'(resp_hit), 64'd0);
        do_lookup(39'h108000, 0);
        chk("repl0 new paddr", 64'(resp_paddr), 64'h208000);
        do_fill(27'h109, PSIZE_4K, (32'h209 << 10) | 32'h47);
        do_lookup(39'h101000, 0);
        chk("repl1 evicted", 64'(resp_hit), 64'd0);
        do_fill(27'h105, PSIZE_4K, (32'h305 << 10) | 32'h47);
        do_fill(27'h10A, PSIZE_4K, (32'h20A << 10) | 32'h47);
        do_lookup(39'h102000, 0);
        chk("repl2 evicted", 64'(resp_hit), 64'd0);
        do_lookup(39'h103000, 0);
        chk("repl3 kept", 64'(resp_hit), 64'd1);
        do_lookup(39'h105000, 0);
        chk("refill in place", 64'(resp_paddr), 64'h305000);

        // Flush by address of a 1GB entry, then flush all.
        do_flush(0, '0);
        do_fill(27'h0040000, PSIZE_1G, 32'h10000047);
        do_fill(27'h12345, PSIZE_4K, 32'h002AF087);
        do_fill(27'h400, PSIZE_2M, 32'h0010004B);
        do_lookup(39'h40001000, 0);
        chk("1g before flush", 64'(resp_paddr), 64'h40001000);
        do_flush(1, 39'h4ABCDEF0);
        do_lookup(39'h40001000, 0);
        chk("1g flushed", 64'(resp_hit), 64'd0);
        do_lookup(39'h12345678, 0);
        chk("4k survives", 64'(resp_hit), 64'd1);
        do_lookup(39'h412345, 0);
        chk("2m survives", 64'(resp_hit), 64'd1);
        do_flush(0, '0);
        do_lookup(39'h12345678, 0);
        chk("flush all 4k", 64'(resp_hit), 64'd0);
        do_lookup(39'h412345, 0);
        chk("flush all 2m", 64'(resp_hit), 64'd0);

        // Lookup alongside flush-all sees old contents; fill alongside flush is dropped.
        do_fill(27'h12345, PSIZE_4K, 32'h002AF087);
        clear_inputs();
        lookup_valid = 1; lookup_vaddr = 39'h12345678; set_acc(0);
        flush_valid = 1; flush_by_addr = 0;
        tick();
        clear_inputs();
        chk("lookup with flush", 64'(resp_hit), 64'd1);
        do_lookup(39'h12345678, 0);
        chk("lookup after flush", 64'(resp_hit), 64'd0);
        flush_valid = 1; flush_by_addr = 0;
        fill_valid = 1; fill_vpn = 27'h12345; fill_psize = PSIZE_4K; fill_pte = 32'h002AF087;
        tick();
        clear_inputs();
        do_lookup(39'h12345678, 0);
        chk("fill dropped", 64'(resp_hit), 64'd0);

        // Reset while a response is pending.
        do_fill(27'h12345, PSIZE_4K, 32'h002AF087);
        clear_inputs();
        lookup_valid = 1; lookup_vaddr = 39'h12345678; set_acc(0);
        tick();
        chk("pending resp", 64'(resp_valid), 64'd1);
        do_reset();
        chk("post reset valid", 64'(resp_valid), 64'd0);
        do_lookup(39'h12345678, 0);
        chk("post reset miss", 64'(resp_hit), 64'd0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                lookup_valid  = $urandom_range(0, 3) != 0;
                lookup_vaddr  = {rand_vpn(), 12'($urandom())};
                set_acc($urandom_range(0, 2));
                u_mode        = 1'($urandom());
                sum           = 1'($urandom());
                fill_valid    = $urandom_range(0, 3) == 0;
                fill_vpn      = rand_vpn();
                fill_psize    = psize_t'(2'($urandom_range(0, 2)));
                fill_pte      = $urandom();
                fill_pte[0]   = $urandom_range(0, 7) != 0;
                flush_valid   = $urandom_range(0, 19) == 0;
                flush_by_addr = 1'($urandom());
                flush_vaddr   = {rand_vpn(), 12'($urandom())};
                tick();
            end
        end
        clear_inputs();
        tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
